// File: rtl/cl_matrix_done_tracker_if.sv
// rtl/cl_matrix_done_tracker_if.sv - job control, write-response and status signals of the done tracker
interface cl_matrix_done_tracker_if #(
  parameter int CNT_W = 16,
  parameter int JOB_W = 16
);
  logic             start;
  logic [CNT_W-1:0] expected_cnt;
  logic             wr_resp_valid;
  logic             wr_resp_err;
  logic             clr_status;
  logic             matrix_calc_done;
  logic             busy;
  logic [CNT_W-1:0] resp_cnt;
  logic [JOB_W-1:0] jobs_done;
  logic             resp_err;
  logic             stray_err;
  logic             restart_err;
  logic             timeout_flag;

  modport master (
    output start, expected_cnt, wr_resp_valid, wr_resp_err, clr_status,
    input  matrix_calc_done, busy, resp_cnt, jobs_done,
           resp_err, stray_err, restart_err, timeout_flag
  );

  modport slave (
    input  start, expected_cnt, wr_resp_valid, wr_resp_err, clr_status,
    output matrix_calc_done, busy, resp_cnt, jobs_done,
           resp_err, stray_err, restart_err, timeout_flag
  );
endinterface

// File: rtl/cl_matrix_done_tracker.sv
// rtl/cl_matrix_done_tracker.sv - tracks one matrix job to its last write response, pulses matrix_calc_done
// Optional response watchdog enabled by defining CL_MATRIX_DONE_TIMEOUT_EN.
module cl_matrix_done_tracker #(
  parameter int CNT_W = 16,
  parameter int JOB_W = 16
`ifdef CL_MATRIX_DONE_TIMEOUT_EN
  ,
  parameter int          TO_W    = 24,
  parameter int unsigned TIMEOUT = 24'hFFFFFF
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cl_matrix_done_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] resp_cnt_q, resp_cnt_d;
  logic [CNT_W-1:0] resp_inc;
  logic [JOB_W-1:0] jobs_done_q, jobs_done_d;
  logic             resp_err_q, resp_err_d;
  logic             stray_err_q, stray_err_d;
  logic             restart_err_q, restart_err_d;
  logic             stray_set, restart_set;

`ifdef CL_MATRIX_DONE_TIMEOUT_EN
  logic [TO_W-1:0] wd_q, wd_d, wd_inc;
  logic            timeout_q, timeout_d;
  logic            wd_expire;

  // Watchdog only runs in RUN; any response restarts the idle window.
  always_comb begin
    wd_inc    = wd_q + 1'b1;
    wd_d      = '0;
    wd_expire = 1'b0;
    if (state_q == ST_RUN && !bus.wr_resp_valid) begin
      wd_d      = wd_inc;
      wd_expire = (wd_inc == TO_W'(TIMEOUT - 1));
    end
    timeout_d = (timeout_q & ~bus.clr_status) | wd_expire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_flag = timeout_q;
`else
  logic wd_expire;
  assign wd_expire        = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    resp_cnt_d  = resp_cnt_q;
    jobs_done_d = jobs_done_q;
    stray_set   = 1'b0;
    restart_set = 1'b0;
    resp_inc    = resp_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        stray_set = bus.wr_resp_valid;
        if (bus.start) begin
          target_d   = bus.expected_cnt;
          resp_cnt_d = '0;
          state_d    = (bus.expected_cnt == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        restart_set = bus.start;
        if (bus.wr_resp_valid) begin
          resp_cnt_d = resp_inc;
          if (resp_inc == target_q) state_d = ST_DONE;
        end else if (wd_expire) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        stray_set   = bus.wr_resp_valid;
        restart_set = bus.start;
        jobs_done_d = jobs_done_q + 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A set in the same cycle as clr_status takes precedence.
    resp_err_d    = (resp_err_q    & ~bus.clr_status) | (bus.wr_resp_valid & bus.wr_resp_err);
    stray_err_d   = (stray_err_q   & ~bus.clr_status) | stray_set;
    restart_err_d = (restart_err_q & ~bus.clr_status) | restart_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      resp_cnt_q    <= '0;
      jobs_done_q   <= '0;
      resp_err_q    <= 1'b0;
      stray_err_q   <= 1'b0;
      restart_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      resp_cnt_q    <= resp_cnt_d;
      jobs_done_q   <= jobs_done_d;
      resp_err_q    <= resp_err_d;
      stray_err_q   <= stray_err_d;
      restart_err_q <= restart_err_d;
    end
  end

  assign bus.matrix_calc_done = (state_q == ST_DONE);
  assign bus.busy             = (state_q == ST_RUN);
  assign bus.resp_cnt         = resp_cnt_q;
  assign bus.jobs_done        = jobs_done_q;
  assign bus.resp_err         = resp_err_q;
  assign bus.stray_err        = stray_err_q;
  assign bus.restart_err      = restart_err_q;

endmodule
